// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared state encoding and widths for the SR latch driver
package sr_pkg;

    localparam int CNT_W      = 4;
    localparam int CONF_CNT_W = 8;

    localparam logic [CONF_CNT_W-1:0] CONF_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } sr_state_t;

endpackage

// File: rtl/sr_pulse_timer.sv
// rtl/sr_pulse_timer.sv - loadable down-counter timing both pulse and gap phases
module sr_pulse_timer
    import sr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Holds at zero once expired; a load always takes priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sr_drive_ctrl.sv
// rtl/sr_drive_ctrl.sv - active-low S/R pulse driver for a NAND SR latch; SR_DRV_CONFLICT_CNT_EN adds conflict_cnt
module sr_drive_ctrl
    import sr_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic ready,
    output logic S,
    output logic R,
    output logic q_model,
    output logic conflict
`ifdef SR_DRV_CONFLICT_CNT_EN
    ,
    output logic [CONF_CNT_W-1:0] conflict_cnt
`endif
);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

    sr_state_t        state;
    sr_state_t        state_nxt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    sr_pulse_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Clear wins when both requests arrive together.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = PULSE_R;
                    tmr_load  = 1'b1;
                    tmr_val   = PULSE_LD;
                end else if (set_req) begin
                    state_nxt = PULSE_S;
                    tmr_load  = 1'b1;
                    tmr_val   = PULSE_LD;
                end
            end
            PULSE_S, PULSE_R: begin
                if (tmr_done) begin
                    state_nxt = GAP;
                    tmr_load  = 1'b1;
                    tmr_val   = GAP_LD;
                end
            end
            GAP: begin
                if (tmr_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the single next state, so S and R can never both be low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            S        <= 1'b1;
            R        <= 1'b1;
            q_model  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready    <= (state_nxt == IDLE);
            S        <= (state_nxt != PULSE_S);
            R        <= (state_nxt != PULSE_R);
            conflict <= (state == IDLE) && set_req && clr_req;
            if ((state == PULSE_S || state == PULSE_R) && state_nxt == GAP) begin
                q_model <= (state == PULSE_S);
            end
        end
    end

`ifdef SR_DRV_CONFLICT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (conflict && conflict_cnt != CONF_CNT_MAX) begin
            conflict_cnt <= conflict_cnt + CONF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 Parameter: PULSE_W, default 4, width in clk cycles of one active-low S or R pulse (legal 1..15).
REQ-002 Parameter: GAP_W, default 1, idle cycles with S=R=1 after every pulse (legal 1..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 set_req  input  1  request to set the downstream latch (Q=1); sampled only when ready=1.
REQ-006 clr_req  input  1  request to reset the downstream latch (Q=0); sampled only when ready=1.
REQ-007 ready  output  1  high when a new request is accepted this cycle.
REQ-008 S  output  1  active-low set drive to the NAND SR latch.
REQ-009 R  output  1  active-low reset drive to the NAND SR latch.
REQ-010 q_model  output  1  expected latch Q after the last completed pulse.
REQ-011 conflict  output  1  one-cycle pulse when set_req and clr_req are both high at acceptance.

Function
REQ-012 States: IDLE, PULSE_S, PULSE_R, GAP; registered outputs, no combinational path from inputs to S/R.
REQ-013 IDLE: ready=1, S=1, R=1.
REQ-014 IDLE with set_req=1, clr_req=0 -> PULSE_S next cycle; S=0 for exactly PULSE_W cycles.
REQ-015 IDLE with clr_req=1, set_req=0 -> PULSE_R next cycle; R=0 for exactly PULSE_W cycles.
REQ-016 IDLE with both high: clear wins -> PULSE_R; conflict=1 in the cycle after acceptance.
REQ-017 Pulse end -> GAP; S=R=1 for exactly GAP_W cycles; then IDLE.
REQ-018 ready=0 in PULSE_S, PULSE_R, GAP; requests in those states are ignored, not queued.
REQ-019 S=0 and R=0 in the same cycle never occurs, under any input sequence including reset.
REQ-020 q_model updates to 1 (after PULSE_S) or 0 (after PULSE_R) in the first GAP cycle.
REQ-021 Pulse/gap counter 4 bits, down-counting, loaded with W-1 on state entry; no wrap beyond zero.
REQ-022 Latency: request accepted at edge N -> S or R low from edge N+1 to edge N+PULSE_W; ready high again at edge N+PULSE_W+GAP_W+1.
REQ-023 Back-to-back same-direction requests are each issued as full pulses, separated by GAP_W.

Reset
REQ-024 rst=1 at any edge, including mid-pulse: state=IDLE, S=1, R=1, ready=1, q_model=0, conflict=0, counter=0.
REQ-025 Reset mid-PULSE_S/PULSE_R terminates the pulse on the next edge; q_model is not updated by the aborted pulse.

Configuration
REQ-026 Macro SR_DRV_CONFLICT_CNT_EN defined: extra output conflict_cnt [7:0], increments on each conflict pulse, saturates at 255, reset to 0.
REQ-027 Macro SR_DRV_CONFLICT_CNT_EN undefined: no conflict_cnt port or counter; all other behaviour identical.

Structure
REQ-028 Shared package sr_pkg holds the state enum (IDLE, PULSE_S, PULSE_R, GAP), counter width constant (4) and conflict counter width (8).
REQ-029 One sub-module sr_pulse_timer: loadable 4-bit down-counter with done flag, used for both pulse and gap timing.
REQ-030 Block drives the existing NAND SR latch directly: S→S, R→R.

Verification
REQ-031 Reset then set_req=1 one cycle (PULSE_W=4, GAP_W=1) -> S low 4 cycles, ready low 5 cycles, q_model=1.
REQ-032 set_req=clr_req=1 in IDLE -> R low 4 cycles, S stays 1, conflict=1 one cycle, q_model=0.
REQ-033 rst asserted at 2nd cycle of PULSE_S -> next edge S=1, ready=1, q_model=0.
REQ-034 Random set/clr stream, 10,000 cycles -> assertion S|R==1 every cycle; q_model matches latch Q after each GAP.
REQ-035 set_req held high 3 cycles during PULSE_R -> ignored; only one R pulse issued.
REQ-036 With SR_DRV_CONFLICT_CNT_EN, 300 conflicting requests -> conflict_cnt=255.
